// File: rtl/data_split_if.sv
// Stream bundle for the wide-to-narrow splitter. The wide word enters from upstream and the narrow beats leave to downstream.
// The slave modport is the splitter side; the master modport is the surrounding logic that drives it.
interface data_split_if #(
  parameter int INPUT_DATA_WIDTH  = 1024,
  parameter int OUTPUT_DATA_WIDTH = 256,
  parameter int CNT_W             = 3
);
  logic [INPUT_DATA_WIDTH-1:0]  data_in;
  logic [CNT_W-1:0]             beats_in;
  logic                         last_in;
  logic                         valid_in;
  logic                         ready_out;
  logic [OUTPUT_DATA_WIDTH-1:0] data_out;
  logic                         valid_out;
  logic                         last_out;
  logic                         ready_in;

  modport slave (
    input  data_in, beats_in, last_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, last_out
  );

  modport master (
    output data_in, beats_in, last_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, last_out
  );
endinterface

// File: rtl/data_split.sv
// Wide-to-narrow width converter: one wide word in, up to SPLIT_LEVEL narrow beats out, LSB slice first.
// A per-word beat count allows a short tail word, and the last flag marks the final beat of the stream.
module data_split #(
  parameter int INPUT_DATA_WIDTH  = 1024,
  parameter int OUTPUT_DATA_WIDTH = 256,
  parameter int SPLIT_LEVEL       = INPUT_DATA_WIDTH / OUTPUT_DATA_WIDTH,
  parameter int CNT_W             = $clog2(SPLIT_LEVEL) + 1
) (
  input  logic           clk,
  input  logic           areset,
  input  logic           ap_start,
  data_split_if.slave    bus
);

  logic [INPUT_DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]            remain;
  logic                        last_reg;
  logic                        fire_in;
  logic                        fire_out;

  // A zero count or an out-of-range count both mean a full word.
  function automatic logic [CNT_W-1:0] clamp_beats(input logic [CNT_W-1:0] b);
    if (b == '0 || int'(b) > SPLIT_LEVEL) return CNT_W'(SPLIT_LEVEL);
    return b;
  endfunction

  function automatic logic [INPUT_DATA_WIDTH-1:0] next_slice(input logic [INPUT_DATA_WIDTH-1:0] w);
    if (SPLIT_LEVEL > 1) return w >> OUTPUT_DATA_WIDTH;
    return w;
  endfunction

  assign bus.valid_out = (remain != '0);
  assign bus.data_out  = shift_reg[OUTPUT_DATA_WIDTH-1:0];
  assign bus.last_out  = last_reg && (remain == CNT_W'(1));
  // Accepting on the final beat lets the next word follow without a bubble.
  assign bus.ready_out = !areset && !ap_start &&
                         ((remain == '0) || ((remain == CNT_W'(1)) && bus.ready_in));

  assign fire_in  = bus.valid_in && bus.ready_out;
  assign fire_out = bus.valid_out && bus.ready_in;

  always_ff @(posedge clk) begin
    if (areset || ap_start) begin
      shift_reg <= '0;
      remain    <= '0;
      last_reg  <= 1'b0;
    end else if (fire_in) begin
      shift_reg <= bus.data_in;
      remain    <= clamp_beats(bus.beats_in);
      last_reg  <= bus.last_in;
    end else if (fire_out) begin
      shift_reg <= next_slice(shift_reg);
      remain    <= remain - CNT_W'(1);
      if (remain == CNT_W'(1)) last_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_split.sv
// Directed and randomized-backpressure bench for data_split (1024b -> 4 x 256b).
module tb_data_split;
  localparam int IW = 1024;
  localparam int OW = 256;
  localparam int SL = 4;
  localparam int CW = 3;
  localparam int N_RAND = 1000;

  logic clk = 1'b0;
  logic areset;
  logic ap_start;
  always #5 clk = ~clk;

  data_split_if #(.INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW), .CNT_W(CW)) bus ();

  data_split #(
    .INPUT_DATA_WIDTH (IW),
    .OUTPUT_DATA_WIDTH(OW),
    .SPLIT_LEVEL      (SL),
    .CNT_W            (CW)
  ) dut (
    .clk     (clk),
    .areset  (areset),
    .ap_start(ap_start),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
  } beat_t;
  beat_t exp_q[$];

  logic [IW-1:0] rw;
  logic [CW-1:0] rb;
  logic          rl;
  int            sent;
  int            cyc;
  logic          have;
  logic          stalled;
  logic [OW-1:0] prev_d;
  logic          prev_l;
  beat_t         eb;
  int            nb;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    check(tag, {{(OW-1){1'b0}}, got}, {{(OW-1){1'b0}}, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] beat_pat(input logic [15:0] id, input int k);
    return {8{id, 16'(k)}};
  endfunction

  function automatic logic [IW-1:0] word_pat(input logic [15:0] id);
    logic [IW-1:0] w;
    for (int k = 0; k < SL; k++) w[k*OW +: OW] = beat_pat(id, k);
    return w;
  endfunction

  task automatic expect_beat(input string tag, input logic [OW-1:0] d, input logic l);
    check_bit({tag, "_vld"}, bus.valid_out, 1'b1);
    check({tag, "_dat"}, bus.data_out, d);
    check_bit({tag, "_last"}, bus.last_out, l);
  endtask

  // Send one word from idle with ready_in high and expect n beats then idle.
  task automatic run_word(input logic [15:0] id, input logic [CW-1:0] b, input logic l, input int n);
    tick();
    bus.valid_in = 1'b1;
    bus.data_in  = word_pat(id);
    bus.beats_in = b;
    bus.last_in  = l;
    bus.ready_in = 1'b1;
    @(negedge clk);
    check_bit("rw_rdy", bus.ready_out, 1'b1);
    tick();
    bus.valid_in = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      expect_beat("rw_beat", beat_pat(id, k), l && (k == n - 1));
      if (k < n - 1) tick();
    end
    tick();
    @(negedge clk);
    check_bit("rw_idle", bus.valid_out, 1'b0);
  endtask

  initial begin
    // Reset held two cycles with valid_in high
    areset       = 1'b1;
    ap_start     = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = word_pat(16'hFFFF);
    bus.beats_in = 3'd4;
    bus.last_in  = 1'b0;
    bus.ready_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      check_bit("rst_vld", bus.valid_out, 1'b0);
      check("rst_dat", bus.data_out, '0);
      check_bit("rst_last", bus.last_out, 1'b0);
      check_bit("rst_rdy", bus.ready_out, 1'b0);
    end
    tick();
    areset       = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    check_bit("post_rst_rdy", bus.ready_out, 1'b1);
    check_bit("post_rst_vld", bus.valid_out, 1'b0);

    // Full word followed back-to-back by a second word
    tick();
    bus.valid_in = 1'b1;
    bus.data_in  = word_pat(16'h1111);
    bus.beats_in = 3'd4;
    bus.last_in  = 1'b0;
    @(negedge clk);
    check_bit("t2_rdy0", bus.ready_out, 1'b1);
    tick();
    bus.data_in = word_pat(16'h2222);
    for (int k = 0; k < SL; k++) begin
      @(negedge clk);
      expect_beat("t2_w1", beat_pat(16'h1111, k), 1'b0);
      check_bit("t2_rdy", bus.ready_out, k == SL - 1);
      tick();
    end
    bus.valid_in = 1'b0;
    for (int k = 0; k < SL; k++) begin
      @(negedge clk);
      expect_beat("t2_w2", beat_pat(16'h2222, k), 1'b0);
      tick();
    end
    @(negedge clk);
    check_bit("t2_idle", bus.valid_out, 1'b0);

    // Tail word and beat-count clamping
    run_word(16'h3333, 3'd2, 1'b1, 2);
    run_word(16'h4444, 3'd0, 1'b0, 4);
    run_word(16'h5555, 3'd7, 1'b1, 4);

    // ap_start flush mid-word
    tick();
    bus.valid_in = 1'b1;
    bus.data_in  = word_pat(16'h6666);
    bus.beats_in = 3'd4;
    bus.last_in  = 1'b1;
    @(negedge clk);
    check_bit("ap_rdy0", bus.ready_out, 1'b1);
    tick();
    bus.valid_in = 1'b0;
    @(negedge clk);
    expect_beat("ap_b0", beat_pat(16'h6666, 0), 1'b0);
    tick();
    @(negedge clk);
    expect_beat("ap_b1", beat_pat(16'h6666, 1), 1'b0);
    tick();
    ap_start = 1'b1;
    @(negedge clk);
    check_bit("ap_rdy_pulse", bus.ready_out, 1'b0);
    tick();
    ap_start = 1'b0;
    @(negedge clk);
    check_bit("ap_vld", bus.valid_out, 1'b0);
    check("ap_dat", bus.data_out, '0);
    check_bit("ap_last", bus.last_out, 1'b0);
    check_bit("ap_rdy", bus.ready_out, 1'b1);
    run_word(16'h7777, 3'd4, 1'b1, 4);

    // Random words under random backpressure against a reference split
    sent    = 0;
    cyc     = 0;
    have    = 1'b0;
    stalled = 1'b0;
    prev_d  = '0;
    prev_l  = 1'b0;
    while ((sent < N_RAND || have || exp_q.size() != 0) && cyc < 60000) begin
      tick();
      cyc++;
      if (!have && sent < N_RAND) begin
        for (int j = 0; j < IW / 32; j++) rw[j*32 +: 32] = $urandom;
        rb = CW'($urandom_range(0, 7));
        rl = 1'($urandom_range(0, 1));
        bus.valid_in = 1'b1;
        bus.data_in  = rw;
        bus.beats_in = rb;
        bus.last_in  = rl;
        have = 1'b1;
        sent++;
      end else if (!have) begin
        bus.valid_in = 1'b0;
      end
      bus.ready_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) begin
        check_bit("bp_hold_vld", bus.valid_out, 1'b1);
        check("bp_hold_dat", bus.data_out, prev_d);
        check_bit("bp_hold_last", bus.last_out, prev_l);
      end
      if (bus.valid_out && bus.ready_in) begin
        if (exp_q.size() == 0) begin
          check_bit("bp_extra_beat", 1'b1, 1'b0);
        end else begin
          eb = exp_q.pop_front();
          check("bp_dat", bus.data_out, eb.d);
          check_bit("bp_last", bus.last_out, eb.l);
        end
      end
      if (bus.valid_in && bus.ready_out) begin
        nb = (rb == 0 || int'(rb) > SL) ? SL : int'(rb);
        for (int k = 0; k < nb; k++) begin
          eb.d = rw[k*OW +: OW];
          eb.l = rl && (k == nb - 1);
          exp_q.push_back(eb);
        end
        have = 1'b0;
      end
      stalled = bus.valid_out && !bus.ready_in;
      prev_d  = bus.data_out;
      prev_l  = bus.last_out;
    end
    check("bp_sent", OW'(sent), OW'(N_RAND));
    check("bp_pending", OW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
